// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back / write-allocate L2 cache, one request in flight.
// Optional performance counters are built when L2_PERF_CNT_EN is defined.
module l2_cache_nway #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SET_WIDTH  = 6,
  parameter int WAYS       = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  store,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  hit,
  output logic                  miss,
  output logic                  resp_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [CNT_WIDTH-1:0]  wb_count
);

  localparam int SETS  = 1 << SET_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - SET_WIDTH - 2;
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WRITEBACK, S_REFILL, S_RESPOND
  } state_t;

  state_t                       state_q, state_d;
  logic [WA_W-1:0]              waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic                         store_q, store_d;
  logic [WAY_W-1:0]             victim_q, victim_d;
  logic [DATA_WIDTH-1:0]        data_out_q, data_out_d;
  logic [WAYS-1:0][SETS-1:0]    valid_q, valid_d;
  logic [WAYS-1:0][SETS-1:0]    dirty_q, dirty_d;
  logic [SETS-1:0][WAY_W-1:0]   rr_q, rr_d;

  logic [SET_WIDTH-1:0]         idx_q, idx_in;
  logic [TAG_W-1:0]             tag_q;
  logic                         unused_addr_bits;

  logic [WAYS-1:0][TAG_W-1:0]      rd_tag;
  logic [WAYS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [WAYS-1:0]                 match;
  logic                            any_hit;
  logic [WAY_W-1:0]                hit_way, free_way;

  logic                  mem_we;
  logic [WAY_W-1:0]      mem_way;
  logic [TAG_W-1:0]      mem_wtag;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;

  assign idx_q            = waddr_q[SET_WIDTH-1:0];
  assign tag_q            = waddr_q[WA_W-1:SET_WIDTH];
  assign idx_in           = address[SET_WIDTH+1:2];
  assign unused_addr_bits = ^address[1:0];
  assign busy             = (state_q != S_IDLE);
  // Arrays are read at the accepting edge, so COMPARE sees registered tag/data.
  assign rd_en            = (state_q == S_IDLE);
  assign any_hit          = |match;

  function automatic logic [WAY_W-1:0] rr_inc(input logic [WAY_W-1:0] p);
    if (p == WAY_W'(WAYS - 1)) rr_inc = '0;
    else                       rr_inc = p + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]      tag_mem  [SETS];
      logic [DATA_WIDTH-1:0] data_mem [SETS];
      logic [TAG_W-1:0]      rd_tag_q;
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge clk) begin
        if (mem_we && (mem_way == WAY_W'(gi))) begin
          tag_mem[idx_q]  <= mem_wtag;
          data_mem[idx_q] <= mem_wdata;
        end
        if (rd_en) begin
          rd_tag_q  <= tag_mem[idx_in];
          rd_data_q <= data_mem[idx_in];
        end
      end

      assign rd_tag[gi]  = rd_tag_q;
      assign rd_data[gi] = rd_data_q;
      assign match[gi]   = valid_q[gi][idx_q] && (rd_tag_q == tag_q);
    end
  endgenerate

  // Lowest index wins for both the hit way and the first free way.
  always_comb begin
    hit_way  = '0;
    free_way = rr_q[idx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])            hit_way  = WAY_W'(w);
      if (!valid_q[w][idx_q])  free_way = WAY_W'(w);
    end
  end

  always_comb begin
    state_d        = state_q;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    store_d        = store_q;
    victim_d       = victim_q;
    data_out_d     = data_out_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    rr_d           = rr_q;
    mem_we         = 1'b0;
    mem_way        = victim_q;
    mem_wtag       = tag_q;
    mem_wdata      = wdata_q;
    hit            = 1'b0;
    miss           = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    data_out       = data_out_q;

    case (state_q)
      S_IDLE: begin
        if (load || store) begin
          waddr_d = address[ADDR_WIDTH-1:2];
          wdata_d = data_in;
          store_d = store;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (any_hit) begin
          hit        = 1'b1;
          resp_valid = 1'b1;
          state_d    = S_IDLE;
          if (store_q) begin
            mem_we                  = 1'b1;
            mem_way                 = hit_way;
            dirty_d[hit_way][idx_q] = 1'b1;
          end else begin
            data_out   = rd_data[hit_way];
            data_out_d = rd_data[hit_way];
          end
        end else begin
          miss     = 1'b1;
          victim_d = free_way;
          if (valid_q[free_way][idx_q]) rr_d[idx_q] = rr_inc(rr_q[idx_q]);
          if (valid_q[free_way][idx_q] && dirty_q[free_way][idx_q]) begin
            state_d = S_WRITEBACK;
          end else if (store_q) begin
            mem_we                   = 1'b1;
            mem_way                  = free_way;
            valid_d[free_way][idx_q] = 1'b1;
            dirty_d[free_way][idx_q] = 1'b1;
            state_d                  = S_RESPOND;
          end else begin
            state_d = S_REFILL;
          end
        end
      end
      S_WRITEBACK: begin
        mem_write      = 1'b1;
        mem_addr       = {rd_tag[victim_q], idx_q, 2'b00};
        mem_write_data = rd_data[victim_q];
        if (mem_ready) begin
          if (store_q) begin
            mem_we                   = 1'b1;
            valid_d[victim_q][idx_q] = 1'b1;
            dirty_d[victim_q][idx_q] = 1'b1;
            state_d                  = S_RESPOND;
          end else begin
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        mem_read = 1'b1;
        mem_addr = {tag_q, idx_q, 2'b00};
        if (mem_ready) begin
          mem_we                   = 1'b1;
          mem_wdata                = mem_data;
          valid_d[victim_q][idx_q] = 1'b1;
          dirty_d[victim_q][idx_q] = 1'b0;
          data_out_d               = mem_data;
          state_d                  = S_RESPOND;
        end
      end
      S_RESPOND: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      victim_q   <= '0;
      data_out_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      victim_q   <= victim_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      rr_q       <= rr_d;
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;
  logic                 wb_done;

  assign wb_done = (state_q == S_WRITEBACK) && mem_ready;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit && !(&hit_cnt_q))     hit_cnt_d  = hit_cnt_q + 1'b1;
    if (miss && !(&miss_cnt_q))   miss_cnt_d = miss_cnt_q + 1'b1;
    if (wb_done && !(&wb_cnt_q))  wb_cnt_d   = wb_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed table-driven bench for l2_cache_nway (WAYS=2, SET_WIDTH=6) with a
// 3-cycle memory responder and hand-written reset / busy sequences.
module tb_l2_cache_nway;

  logic        clk = 1'b0;
  logic        rst, load, store, mem_ready;
  logic [31:0] address, data_in, mem_data;
  logic        hit, miss, resp_valid, busy, mem_read, mem_write;
  logic [31:0] data_out, mem_addr, mem_write_data;
  logic [31:0] hit_count, miss_count, wb_count;

`ifdef L2_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  l2_cache_nway #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SET_WIDTH(6), .WAYS(2), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .address(address),
    .data_in(data_in), .mem_data(mem_data), .mem_ready(mem_ready),
    .hit(hit), .miss(miss), .resp_valid(resp_valid), .busy(busy),
    .data_out(data_out), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  typedef struct {
    bit          ld;
    bit          st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    bit          e_hit;
    bit          e_rd;
    logic [31:0] e_rd_addr;
    bit          e_wr;
    logic [31:0] e_wr_addr;
    logic [31:0] e_wr_data;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int total = 0;
  int bad   = 0;

  bit          r_resp, r_hit, r_miss, r_rd, r_wr, r_both;
  int          r_hit_cyc, r_rd_cyc, r_wr_cyc;
  logic [31:0] r_rd_addr, r_wr_addr, r_wr_data, r_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Issues one request and follows it to resp_valid, playing the memory side.
  task automatic do_req(input bit ld, input bit st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] md, input bit poke);
    int wait_cnt;
    wait_cnt  = 0;
    r_resp    = 0; r_hit = 0; r_miss = 0; r_rd = 0; r_wr = 0; r_both = 0;
    r_hit_cyc = -1; r_rd_cyc = -1; r_wr_cyc = -1;
    r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0; r_data = '0;
    load = ld; store = st; address = a; data_in = wd;
    @(posedge clk); #1;
    load = 0; store = 0;
    for (int c = 0; c < 40; c++) begin
      mem_ready = 0;
      load      = 0;
      if (hit && !r_hit) begin r_hit = 1; r_hit_cyc = c; end
      if (miss) r_miss = 1;
      if (mem_read && mem_write) r_both = 1;
      if (mem_read) begin
        if (!r_rd) r_rd_cyc = c;
        r_rd = 1; r_rd_addr = mem_addr;
      end
      if (mem_write) begin
        if (!r_wr) r_wr_cyc = c;
        r_wr = 1; r_wr_addr = mem_addr; r_wr_data = mem_write_data;
      end
      if (resp_valid) begin
        r_resp = 1; r_data = data_out;
        break;
      end
      if (mem_read || mem_write) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          mem_ready = 1; mem_data = md; wait_cnt = 0;
        end
        if (poke && mem_read) begin
          load = 1; address = 32'h0000_0010;
        end
      end
      @(posedge clk); #1;
    end
    mem_ready = 0; load = 0; store = 0;
    @(posedge clk); #1;
  endtask

  task automatic chk_counters(input string tag, input int h, input int m, input int w);
    chk({tag, " hit_count"},  hit_count,  PERF ? 32'(h) : 32'd0);
    chk({tag, " miss_count"}, miss_count, PERF ? 32'(m) : 32'd0);
    chk({tag, " wb_count"},   wb_count,   PERF ? 32'(w) : 32'd0);
  endtask

  initial begin
    //         ld st addr         wdata         mdata         hit rd rd_addr     wr wr_addr      wr_data       data
    vt[0]  = '{1, 0, 32'h004, 32'h0,        32'h11111111, 0, 1, 32'h004, 0, 32'h0,   32'h0,        32'h11111111};
    vt[1]  = '{1, 0, 32'h004, 32'h0,        32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'h11111111};
    vt[2]  = '{0, 1, 32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h0,        32'h0};
    vt[3]  = '{1, 0, 32'h104, 32'h0,        32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'hDEADBEEF};
    vt[4]  = '{1, 0, 32'h204, 32'h0,        32'h22222222, 0, 1, 32'h204, 0, 32'h0,   32'h0,        32'h22222222};
    vt[5]  = '{1, 0, 32'h304, 32'h0,        32'h33333333, 0, 1, 32'h304, 1, 32'h104, 32'hDEADBEEF, 32'h33333333};
    vt[6]  = '{1, 0, 32'h204, 32'h0,        32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'h22222222};
    vt[7]  = '{0, 1, 32'h204, 32'hA5A5A5A5, 32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'h0};
    vt[8]  = '{1, 0, 32'h404, 32'h0,        32'h44444444, 0, 1, 32'h404, 1, 32'h204, 32'hA5A5A5A5, 32'h44444444};
    vt[9]  = '{1, 0, 32'h304, 32'h0,        32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'h33333333};
    vt[10] = '{1, 1, 32'h504, 32'h00000055, 32'h0,        0, 0, 32'h0,   0, 32'h0,   32'h0,        32'h0};
    vt[11] = '{1, 0, 32'h506, 32'h0,        32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'h00000055};
    vt[12] = '{1, 0, 32'h008, 32'h0,        32'h66666666, 0, 1, 32'h008, 0, 32'h0,   32'h0,        32'h66666666};
    vt[13] = '{1, 0, 32'h404, 32'h0,        32'h0,        1, 0, 32'h0,   0, 32'h0,   32'h0,        32'h44444444};

    rst = 1; load = 0; store = 0; address = '0; data_in = '0; mem_data = '0; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset busy", busy, 0);
    chk("reset pulses", {hit, miss, resp_valid}, 0);
    chk("reset mem_rw", {mem_read, mem_write}, 0);
    chk("reset data_out", data_out, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset counters", hit_count | miss_count | wb_count, 0);

    for (int i = 0; i < NV; i++) begin
      do_req(vt[i].ld, vt[i].st, vt[i].addr, vt[i].wdata, vt[i].mdata, 0);
      $display("vec %0d: ld=%0d st=%0d addr=%h hit=%0d rd=%0d wr=%0d data=%h",
               i, vt[i].ld, vt[i].st, vt[i].addr, r_hit, r_rd, r_wr, r_data);
      chk($sformatf("v%0d resp", i), r_resp, 1);
      chk($sformatf("v%0d hit", i), r_hit, vt[i].e_hit);
      chk($sformatf("v%0d miss", i), r_miss, !vt[i].e_hit);
      chk($sformatf("v%0d rd_wr_excl", i), r_both, 0);
      if (vt[i].e_hit) chk($sformatf("v%0d hit_latency", i), r_hit_cyc, 0);
      chk($sformatf("v%0d mem_read", i), r_rd, vt[i].e_rd);
      if (vt[i].e_rd) chk($sformatf("v%0d rd_addr", i), r_rd_addr, vt[i].e_rd_addr);
      chk($sformatf("v%0d mem_write", i), r_wr, vt[i].e_wr);
      if (vt[i].e_wr) begin
        chk($sformatf("v%0d wr_addr", i), r_wr_addr, vt[i].e_wr_addr);
        chk($sformatf("v%0d wr_data", i), r_wr_data, vt[i].e_wr_data);
        chk($sformatf("v%0d wb_before_refill", i), r_wr_cyc < r_rd_cyc, 1);
      end
      if (vt[i].ld && !vt[i].st) chk($sformatf("v%0d data_out", i), r_data, vt[i].e_data);
      if (i == 5) chk_counters("after6", 2, 4, 1);
    end

    // Reset while a refill is outstanding.
    load = 1; address = 32'h004;
    @(posedge clk); #1;
    load = 0;
    chk("rstseq busy_compare", busy, 1);
    chk("rstseq miss", miss, 1);
    @(posedge clk); #1;
    chk("rstseq mem_read_refill", mem_read, 1);
    chk("rstseq mem_addr_refill", mem_addr, 32'h004);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    $display("rstseq: busy=%0d mem_read=%0d", busy, mem_read);
    chk("rstseq busy_after", busy, 0);
    chk("rstseq mem_read_after", mem_read, 0);
    chk_counters("rstseq", 0, 0, 0);

    do_req(1, 0, 32'h004, 32'h0, 32'h77777777, 0);
    $display("post-rst load 004: hit=%0d rd=%0d data=%h", r_hit, r_rd, r_data);
    chk("postrst miss", r_miss, 1);
    chk("postrst rd_addr", r_rd_addr, 32'h004);
    chk("postrst wr", r_wr, 0);
    chk("postrst data", r_data, 32'h77777777);
    do_req(1, 0, 32'h004, 32'h0, 32'h0, 0);
    $display("post-rst reload 004: hit=%0d data=%h", r_hit, r_data);
    chk("postrst hit", r_hit, 1);
    chk("postrst hit_data", r_data, 32'h77777777);
    chk_counters("postrst", 1, 1, 0);

    // A load presented while busy must be dropped, not replayed afterwards.
    do_req(1, 0, 32'h00C, 32'h0, 32'h88888888, 1);
    $display("busy-poke load 00C: rd=%0d data=%h busy=%0d", r_rd, r_data, busy);
    chk("poke data", r_data, 32'h88888888);
    chk("poke busy_idle", busy, 0);
    @(posedge clk); #1;
    chk("poke not_queued", {busy, mem_read}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
